seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of common-anode 7-segment digits, generalising the single-digit hex decoder to NUM_DIGITS digits. It latches a packed hex word, decimal-point mask and blank mask via a load strobe, and applies them tear-free at frame boundaries. It scans one digit per slot and drives active-low segment, decimal-point and anode lines. It sits between the display-number datapath and the board's 7-segment pins.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_hex_decode.sv | 15 +
 rtl/seg7_scan_driver.sv | 123 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and glyph lookup for the multiplexed 7-segment display driver.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // MC14495-style hex shapes: 6 with top bar, 7 without f, 9 with d, lowercase b/d
    localparam logic [6:0] GLYPH_N [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nibble);
        return GLYPH_N[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment pattern, with a forced-dark override.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] segN_c
);

    always_comb begin
        segN_c = SEG_OFF;
        if (!blank) segN_c = hex_to_seg_n(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: latches a hex word on load and
// swaps it into the displayed copy only at frame boundaries so a frame never tears.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lzb,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_W-1:0]     shadowData, activeData;
    logic [NUM_DIGITS-1:0] shadowDp, shadowBlank, activeDp, activeBlank;
    logic                  slotEnd, frameWrap;
    logic [3:0]            nibbles [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lzbMask;
    logic                  curBlank;
    logic [6:0]            segC;
    logic [NUM_DIGITS-1:0] anC;

    assign slotEnd   = (cnt == CNT_W'(SCAN_DIV - 1));
    assign frameWrap = slotEnd && (idx == IDX_W'(NUM_DIGITS - 1));

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDigit
        assign nibbles[i] = activeData[4*i +: 4];
        if (i == 0) begin : gUnits
            assign lzbMask[i] = 1'b0;
        end else begin : gUpper
            assign lzbMask[i] = ~|activeData[DATA_W-1:4*i];
        end
    end

    assign curBlank = activeBlank[idx] | (lzb & lzbMask[idx]);

    seg7_hex_decode uDecode (
        .nibble (nibbles[idx]),
        .blank  (curBlank),
        .segN_c (segC)
    );

    always_comb begin
        anC = '1;
        if (cnt >= CNT_W'(BLANK_CYC)) anC[idx] = 1'b0;
    end

    // Slot prescaler and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slotEnd ? '0 : cnt + CNT_W'(1);
            if (slotEnd) idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    // Shadow capture and frame-boundary swap; a load on the wrap cycle bypasses the shadow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadowData  <= '0;
            shadowDp    <= '0;
            shadowBlank <= '1;
            activeData  <= '0;
            activeDp    <= '0;
            activeBlank <= '1;
            pending     <= 1'b0;
        end else begin
            if (load) begin
                shadowData  <= data_in;
                shadowDp    <= dp_in;
                shadowBlank <= blank_in;
            end
            if (frameWrap) begin
                if (load) begin
                    activeData  <= data_in;
                    activeDp    <= dp_in;
                    activeBlank <= blank_in;
                end else if (pending) begin
                    activeData  <= shadowData;
                    activeDp    <= shadowDp;
                    activeBlank <= shadowBlank;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= segC;
            dp_n       <= ~activeDp[idx];
            an_n       <= anC;
            frame_done <= frameWrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with 4 digits, 8-cycle slots, 2 guard cycles.
module tb_seg7_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 8;
    localparam int unsigned BC = 2;
    localparam int unsigned FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lzb = 1'b0;
    logic [15:0] dataIn = '0;
    logic [3:0]  dpIn = '0;
    logic [3:0]  blankIn = '0;
    logic [6:0]  segN;
    logic        dpN;
    logic [3:0]  anN;
    logic        frameDone;
    logic        pending;

    int nChecks = 0;
    int nFail = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lzb;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  dpN;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (dataIn),
        .dp_in      (dpIn),
        .blank_in   (blankIn),
        .lzb        (lzb),
        .seg_n      (segN),
        .dp_n       (dpN),
        .an_n       (anN),
        .frame_done (frameDone),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the 32 cycles following a frame_done cycle
    task automatic pushFrame(input logic [27:0] segs, input logic [3:0] dpMask);
        exp_t e;
        for (int j = 1; j <= FRAME; j++) begin
            int c, d;
            c = (j - 1) % SD;
            d = (j - 1) / SD;
            e.an  = (c >= BC) ? ~(4'b0001 << d) : 4'hF;
            e.seg = segs[d*7 +: 7];
            e.dp  = dpMask[d];
            e.fd  = (j == FRAME);
            sb.push_back(e);
        end
    endtask

    task automatic drainFrame();
        exp_t e;
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge clk);
            e = sb.pop_front();
            check("an_n", 32'(anN), 32'(e.an));
            check("seg_n", 32'(segN), 32'(e.seg));
            check("dp_n", 32'(dpN), 32'(e.dp));
            check("frame_done", 32'(frameDone), 32'(e.fd));
        end
    endtask

    // Called on a frame_done cycle: load, then ride out the current frame
    task automatic loadAndSkip(input vec_t v);
        dataIn = v.data; dpIn = v.dp; blankIn = v.blank; lzb = v.lzb; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("pending_set", 32'(pending), 32'd1);
        repeat (FRAME - 1) @(negedge clk);
        check("pending_clear", 32'(pending), 32'd0);
        check("wrap_pulse", 32'(frameDone), 32'd1);
    endtask

    initial begin
        vecs[0] = '{16'h12AF, 4'b0100, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011};
        vecs[1] = '{16'h0030, 4'b0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[3] = '{16'h0030, 4'b0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h30, 7'h40}, 4'b1111};
        vecs[4] = '{16'h8765, 4'b1001, 4'b1010, 1'b0, {7'h7F, 7'h78, 7'h7F, 7'h12}, 4'b0110};
        vecs[5] = '{16'h9C0E, 4'b0000, 4'b0000, 1'b1, {7'h10, 7'h46, 7'h40, 7'h06}, 4'b1111};
        vecs[6] = '{16'h4DB6, 4'b0000, 4'b0000, 1'b1, {7'h19, 7'h21, 7'h03, 7'h02}, 4'b1111};
        vecs[7] = '{16'h0010, 4'b0010, 4'b0001, 1'b1, {7'h7F, 7'h7F, 7'h79, 7'h7F}, 4'b1101};
        vecs[8] = '{16'hD08D, 4'b0000, 4'b0000, 1'b0, {7'h21, 7'h40, 7'h00, 7'h21}, 4'b1111};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_an_n", 32'(anN), 32'hF);
        check("rst_seg_n", 32'(segN), 32'h7F);
        check("rst_dp_n", 32'(dpN), 32'd1);
        check("rst_frame_done", 32'(frameDone), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;

        // No load: digits stay dark for two frames while scanning continues
        pushFrame({4{7'h7F}}, 4'hF);
        pushFrame({4{7'h7F}}, 4'hF);
        drainFrame();
        drainFrame();

        // Table of display vectors
        foreach (vecs[i]) begin
            loadAndSkip(vecs[i]);
            pushFrame(vecs[i].segs, vecs[i].dpN);
            drainFrame();
        end

        // Two loads in one frame: the later one wins, the earlier never reaches the pins
        dataIn = 16'h1111; dpIn = '0; blankIn = '0; lzb = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("dbl_pending_set", 32'(pending), 32'd1);
        check("no_stale_one", 32'(segN == 7'h79), 32'd0);
        for (int j = 2; j <= FRAME; j++) begin
            @(negedge clk);
            load = (j == 6);
            if (j == 6) dataIn = 16'h2222;
            check("no_stale_one", 32'(segN == 7'h79), 32'd0);
            if (j == FRAME - 1) check("dbl_pending_hold", 32'(pending), 32'd1);
        end
        check("dbl_pending_clear", 32'(pending), 32'd0);
        check("dbl_wrap_pulse", 32'(frameDone), 32'd1);
        pushFrame({4{7'h24}}, 4'hF);
        drainFrame();

        // Load exactly on the wrap cycle goes straight to the active copy
        repeat (FRAME - 1) @(negedge clk);
        dataIn = 16'h5A5A; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("wrap_load_pending", 32'(pending), 32'd0);
        check("wrap_load_pulse", 32'(frameDone), 32'd1);
        pushFrame({7'h12, 7'h08, 7'h12, 7'h08}, 4'hF);
        drainFrame();

        // Asynchronous reset mid-slot discards a pending load
        dataIn = 16'h8888; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("pre_rst_pending", 32'(pending), 32'd1);
        repeat (19) @(negedge clk);
        check("pre_rst_an_n", 32'(anN), 32'hB);
        check("pre_rst_seg_n", 32'(segN), 32'h08);
        #1 rst = 1'b1;
        #1;
        check("async_an_n", 32'(anN), 32'hF);
        check("async_seg_n", 32'(segN), 32'h7F);
        check("async_dp_n", 32'(dpN), 32'd1);
        check("async_frame_done", 32'(frameDone), 32'd0);
        check("async_pending", 32'(pending), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pushFrame({4{7'h7F}}, 4'hF);
        pushFrame({4{7'h7F}}, 4'hF);
        drainFrame();
        drainFrame();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
